// File: rtl/input_event_controller.sv
// Debounced multi-channel button interrupt controller with fixed-priority, ack-held irq.
// Optional per-channel auto-repeat is built when INPUT_AUTOREPEAT_EN is defined.
module input_event_controller #(
  parameter int NUM_CH          = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ID_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int REPEAT_DELAY    = 2000,
  parameter int REPEAT_PERIOD   = 500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn_raw,
  input  logic [NUM_CH-1:0] mask,
  input  logic              irq_ack,
  output logic              irq,
  output logic [ID_W-1:0]   irq_id,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] pressed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic {IDLE, ASSERT} state_t;

  state_t            state;
  logic [NUM_CH-1:0] s1;
  logic [NUM_CH-1:0] s2;
  logic [NUM_CH-1:0] st;
  logic [NUM_CH-1:0] st_q;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] evt;
  logic [NUM_CH-1:0] set_vec;
  logic [NUM_CH-1:0] clr_vec;
  logic [NUM_CH-1:0] elig;
  logic [ID_W-1:0]   sel_id;
  logic              found;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      st   <= '0;
      st_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      s1   <= btn_raw;
      s2   <= s1;
      st_q <= st;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (s2[i] == st[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          st[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign pressed = st;

`ifdef INPUT_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0]  rpt_cnt [NUM_CH];
  logic [NUM_CH-1:0] rpt_first;
  logic [NUM_CH-1:0] rpt_evt;

  // rpt_cnt counts cycles since the press (or last repeat); reloading to 1 on a
  // repeat makes the next hit land exactly REPEAT_PERIOD cycles later.
  always_comb begin
    rpt_evt = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (st[i] && rpt_cnt[i] == (rpt_first[i] ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_PERIOD)))
        rpt_evt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_first <= '1;
      for (int unsigned i = 0; i < NUM_CH; i++) rpt_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (!st[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_first[i] <= 1'b1;
        end else if (rpt_evt[i]) begin
          rpt_cnt[i]   <= RPT_W'(1);
          rpt_first[i] <= 1'b0;
        end else begin
          rpt_cnt[i] <= rpt_cnt[i] + RPT_W'(1);
        end
      end
    end
  end

  assign evt = (st & ~st_q) | rpt_evt;
`else
  assign evt = st & ~st_q;
`endif

  assign set_vec = evt & mask;
  assign elig    = pending & mask;

  always_comb begin
    clr_vec = '0;
    if (state == ASSERT && irq_ack) clr_vec[irq_id] = 1'b1;
  end

  always_comb begin
    sel_id = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (elig[i] && !found) begin
        sel_id = ID_W'(i);
        found  = 1'b1;
      end
    end
  end

  // A coincident new event on the channel being acked keeps its bit set.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      irq    <= 1'b0;
      irq_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            irq_id <= sel_id;
            irq    <= 1'b1;
            state  <= ASSERT;
          end
        end
        ASSERT: begin
          if (irq_ack) begin
            irq   <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          irq   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_event_controller.sv
// Directed testbench for input_event_controller (NUM_CH=8, DEBOUNCE_CYCLES=4).
// Auto-repeat expectations follow INPUT_AUTOREPEAT_EN.
module tb_input_event_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] btn_raw;
  logic [7:0] mask;
  logic       irq_ack;
  logic       irq;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic [7:0] pressed;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_event_controller #(
    .NUM_CH(8),
    .DEBOUNCE_CYCLES(4),
    .ID_W(3),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .mask(mask),
    .irq_ack(irq_ack),
    .irq(irq),
    .irq_id(irq_id),
    .pending(pending),
    .pressed(pressed)
  );

  // Advance n active edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; btn_raw = 8'hFF; mask = 8'hFF; irq_ack = 1'b0;
    step(3);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %0h exp 0", irq); end
    checks++; if (irq_id !== 3'd0) begin errors++; $display("FAIL rst_id got %0h exp 0", irq_id); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL rst_pending got %0h exp 0", pending); end
    checks++; if (pressed !== 8'h00) begin errors++; $display("FAIL rst_pressed got %0h exp 0", pressed); end
    reset = 1'b0;
    step(5);
    checks++; if (pressed !== 8'h00) begin errors++; $display("FAIL rst_pressed_early got %0h exp 0", pressed); end
    step(1);
    checks++; if (pressed !== 8'hFF) begin errors++; $display("FAIL rst_pressed_e5 got %0h exp ff", pressed); end
    step(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq_e6 got %0h exp 0", irq); end
    checks++; if (pending !== 8'hFF) begin errors++; $display("FAIL rst_pending_e6 got %0h exp ff", pending); end
    step(1);
    for (int k = 0; k < 8; k++) begin
      checks++; if (irq !== 1'b1 || irq_id !== 3'(k))
        begin errors++; $display("FAIL rst_drain_%0d got irq=%0h id=%0d exp irq=1 id=%0d", k, irq, irq_id, k); end
      irq_ack = 1'b1; step(1); irq_ack = 1'b0;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_drain_low_%0d got %0h exp 0", k, irq); end
      step(1);
    end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL rst_drained got %0h exp 0", pending); end
    btn_raw = 8'h00;
    step(8);
    checks++; if (pressed !== 8'h00 || irq !== 1'b0)
      begin errors++; $display("FAIL rst_release got pressed=%0h irq=%0h exp 0 0", pressed, irq); end
  endtask

  task automatic test_single_press;
    btn_raw = 8'h04;
    step(5);
    checks++; if (pressed[2] !== 1'b0) begin errors++; $display("FAIL sp_pressed_e4 got %0h exp 0", pressed[2]); end
    step(1);
    checks++; if (pressed[2] !== 1'b1) begin errors++; $display("FAIL sp_pressed_e5 got %0h exp 1", pressed[2]); end
    step(1);
    checks++; if (irq !== 1'b0 || pending !== 8'h04)
      begin errors++; $display("FAIL sp_e6 got irq=%0h pend=%0h exp 0 04", irq, pending); end
    step(1);
    checks++; if (irq !== 1'b1 || irq_id !== 3'd2)
      begin errors++; $display("FAIL sp_irq got irq=%0h id=%0d exp 1 2", irq, irq_id); end
    step(3);
    checks++; if (irq !== 1'b1 || irq_id !== 3'd2)
      begin errors++; $display("FAIL sp_hold got irq=%0h id=%0d exp 1 2", irq, irq_id); end
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    checks++; if (irq !== 1'b0 || pending !== 8'h00)
      begin errors++; $display("FAIL sp_ack got irq=%0h pend=%0h exp 0 00", irq, pending); end
    step(20);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL sp_no_more got %0h exp 0", irq); end
    btn_raw = 8'h00;
    step(8);
  endtask

  task automatic test_bounce;
    int bad;
    bad = 0;
    for (int r = 0; r < 5; r++) begin
      btn_raw = 8'h20;
      for (int c = 0; c < 3; c++) begin
        step(1);
        if (pressed[5] !== 1'b0 || pending[5] !== 1'b0 || irq !== 1'b0) bad++;
      end
      btn_raw = 8'h00;
      for (int c = 0; c < 3; c++) begin
        step(1);
        if (pressed[5] !== 1'b0 || pending[5] !== 1'b0 || irq !== 1'b0) bad++;
      end
    end
    step(8);
    checks++; if (bad != 0) begin errors++; $display("FAIL bounce_cycles got %0d bad exp 0", bad); end
    checks++; if (pressed[5] !== 1'b0 || pending !== 8'h00 || irq !== 1'b0)
      begin errors++; $display("FAIL bounce_end got p=%0h pend=%0h irq=%0h exp 0 0 0", pressed[5], pending, irq); end
  endtask

  task automatic test_priority;
    btn_raw = 8'h42;
    step(8);
    checks++; if (irq !== 1'b1 || irq_id !== 3'd1)
      begin errors++; $display("FAIL pri_first got irq=%0h id=%0d exp 1 1", irq, irq_id); end
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    checks++; if (irq !== 1'b0 || pending !== 8'h40)
      begin errors++; $display("FAIL pri_gap got irq=%0h pend=%0h exp 0 40", irq, pending); end
    step(1);
    checks++; if (irq !== 1'b1 || irq_id !== 3'd6)
      begin errors++; $display("FAIL pri_second got irq=%0h id=%0d exp 1 6", irq, irq_id); end
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    checks++; if (irq !== 1'b0 || pending !== 8'h00)
      begin errors++; $display("FAIL pri_done got irq=%0h pend=%0h exp 0 00", irq, pending); end
    step(3);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL pri_quiet got %0h exp 0", irq); end
    btn_raw = 8'h00;
    step(8);
  endtask

  task automatic test_mask;
    mask = 8'hF7; btn_raw = 8'h08;
    step(8);
    checks++; if (pressed[3] !== 1'b1 || pending[3] !== 1'b0 || irq !== 1'b0)
      begin errors++; $display("FAIL mask_drop got p=%0h pend=%0h irq=%0h exp 1 0 0", pressed[3], pending[3], irq); end
    mask = 8'hFF;
    step(6);
    checks++; if (irq !== 1'b0 || pending !== 8'h00)
      begin errors++; $display("FAIL mask_reopen got irq=%0h pend=%0h exp 0 00", irq, pending); end
    btn_raw = 8'h00;
    step(8);
  endtask

  task automatic test_autorepeat;
    int rises [$];
    logic prev;
`ifdef INPUT_AUTOREPEAT_EN
    int exp_rises [4] = '{0, 20, 30, 40};
    int exp_n = 4;
`else
    int exp_rises [1] = '{0};
    int exp_n = 1;
`endif
    btn_raw = 8'h01;
    step(8);
    prev = 1'b0;
    for (int rel = 0; rel <= 90; rel++) begin
      if (irq === 1'b1 && prev !== 1'b1) rises.push_back(rel);
      prev = irq;
      irq_ack = irq;
      if (rel == 40) btn_raw = 8'h00;
      step(1);
    end
    irq_ack = 1'b0;
    checks++; if (rises.size() != exp_n)
      begin errors++; $display("FAIL rpt_count got %0d exp %0d", rises.size(), exp_n); end
    for (int k = 0; k < exp_n; k++) begin
      if (k < rises.size()) begin
        checks++; if (rises[k] != exp_rises[k])
          begin errors++; $display("FAIL rpt_time_%0d got %0d exp %0d", k, rises[k], exp_rises[k]); end
      end
    end
    checks++; if (irq !== 1'b0 || pending !== 8'h00)
      begin errors++; $display("FAIL rpt_end got irq=%0h pend=%0h exp 0 00", irq, pending); end
  endtask

  task automatic test_reset_mid_irq;
    btn_raw = 8'h10;
    step(8);
    checks++; if (irq !== 1'b1 || irq_id !== 3'd4)
      begin errors++; $display("FAIL rmi_irq got irq=%0h id=%0d exp 1 4", irq, irq_id); end
    btn_raw = 8'h00;
    reset = 1'b1; step(1); reset = 1'b0;
    checks++; if (irq !== 1'b0 || irq_id !== 3'd0 || pending !== 8'h00 || pressed !== 8'h00)
      begin errors++; $display("FAIL rmi_reset got irq=%0h id=%0d pend=%0h pr=%0h exp all 0", irq, irq_id, pending, pressed); end
    step(10);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rmi_after got %0h exp 0", irq); end
  endtask

  initial begin
    test_reset;
    test_single_press;
    test_bounce;
    test_priority;
    test_mask;
    test_autorepeat;
    test_reset_mid_irq;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
